// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and line levels.
// The transmit drain and the receiver both use it.
package uart_pkg;

   typedef enum logic [2:0] {
      UART_IDLE   = 3'd0,
      UART_START  = 3'd1,
      UART_DATA   = 3'd2,
      UART_PARITY = 3'd3,
      UART_STOP   = 3'd4
   } uart_state_t;

   localparam logic UART_START_BIT = 1'b0;
   localparam logic UART_STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: latches the divisor on load (0 becomes 1) and pulses bit_tick each latched_div cycles.
// The tick is combinational on the terminal count. No backpressure; it counts only while en is high.
module uart_baud_cnt #(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic                 en,
   input  logic [DIV_WIDTH-1:0] div,
   output logic                 bit_tick
);

   logic [DIV_WIDTH-1:0] div_q;
   logic [DIV_WIDTH-1:0] cnt;

   assign bit_tick = en && (cnt == div_q - DIV_WIDTH'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q <= '0;
         cnt   <= '0;
      end else if (load) begin
         div_q <= (div == '0) ? DIV_WIDTH'(1) : div;
         cnt   <= '0;
      end else if (en) begin
         cnt <= bit_tick ? '0 : cnt + DIV_WIDTH'(1);
      end
   end

endmodule

// File: rtl/uart_tx_drain.sv
// Pops bytes from the TX FIFO and sends them as 8N1 frames, or as 8E1 when UART_TX_PARITY_EN is defined. tx falls one cycle after the pop.
// The FIFO is sampled only in IDLE, so back-to-back frames are spaced by one extra stop cycle.
module uart_tx_drain
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DIV_WIDTH-1:0]  div,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   input  logic                  fifo_empty,
   output logic                  fifo_pop,
   output logic                  tx,
   output logic                  busy
);

   localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

   uart_state_t           state, state_nxt;
   logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
   logic [CNT_W-1:0]      bit_cnt, bit_cnt_nxt;
   logic                  tx_nxt;
   logic                  bit_tick;

`ifdef UART_TX_PARITY_EN
   logic parity_q;

   always_ff @(posedge clk) begin
      if (reset)
         parity_q <= 1'b0;
      else if (fifo_pop)
         parity_q <= ^fifo_dout;
   end
`endif

   uart_baud_cnt #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
      .clk      (clk),
      .reset    (reset),
      .load     (fifo_pop),
      .en       (state != UART_IDLE),
      .div      (div),
      .bit_tick (bit_tick)
   );

   // tx_nxt is the line level for the following cycle, so tx stays a clean register output.
   always_comb begin
      state_nxt   = state;
      shreg_nxt   = shreg;
      bit_cnt_nxt = bit_cnt;
      tx_nxt      = UART_STOP_BIT;
      fifo_pop    = 1'b0;
      case (state)
         UART_IDLE: begin
            if (!fifo_empty && !reset) begin
               fifo_pop    = 1'b1;
               state_nxt   = UART_START;
               shreg_nxt   = fifo_dout;
               bit_cnt_nxt = '0;
               tx_nxt      = UART_START_BIT;
            end
         end
         UART_START: begin
            tx_nxt = UART_START_BIT;
            if (bit_tick) begin
               state_nxt = UART_DATA;
               tx_nxt    = shreg[0];
            end
         end
         UART_DATA: begin
            tx_nxt = shreg[0];
            if (bit_tick) begin
               if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
                  state_nxt = UART_PARITY;
                  tx_nxt    = parity_q;
`else
                  state_nxt = UART_STOP;
                  tx_nxt    = UART_STOP_BIT;
`endif
               end else begin
                  bit_cnt_nxt = bit_cnt + CNT_W'(1);
                  shreg_nxt   = shreg >> 1;
                  tx_nxt      = shreg_nxt[0];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         UART_PARITY: begin
            tx_nxt = parity_q;
            if (bit_tick)
               state_nxt = UART_STOP;
         end
`endif
         UART_STOP: begin
            if (bit_tick)
               state_nxt = UART_IDLE;
         end
         default: state_nxt = UART_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= UART_IDLE;
         tx      <= UART_STOP_BIT;
         shreg   <= '0;
         bit_cnt <= '0;
      end else begin
         state   <= state_nxt;
         tx      <= tx_nxt;
         shreg   <= shreg_nxt;
         bit_cnt <= bit_cnt_nxt;
      end
   end

   assign busy = (state != UART_IDLE) || fifo_pop;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: directed frame table, multi-cycle corner sequences and random traffic.
// Everything is checked each cycle against a waveform-list reference model.
module tb_uart_tx_drain;

`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int FB   = 10 + P;
   localparam int MAXC = 40000;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] div;
   logic [7:0]  fifo_dout;
   logic        fifo_empty;
   logic        fifo_pop;
   logic        tx;
   logic        busy;

   uart_tx_drain dut (
      .clk        (clk),
      .reset      (reset),
      .div        (div),
      .fifo_dout  (fifo_dout),
      .fifo_empty (fifo_empty),
      .fifo_pop   (fifo_pop),
      .tx         (tx),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   logic        chk_en  = 1'b0;
   logic        rst_drv = 1'b1;
   logic [15:0] div_drv = 16'd4;
   logic [7:0]  fq[$];
   logic        exp_q[$];
   logic        tx_hist   [0:MAXC-1];
   logic        pop_hist  [0:MAXC-1];
   logic        busy_hist [0:MAXC-1];
   logic        tx_s, pop_s, busy_s;

   typedef struct {
      logic [7:0]  data;
      logic [15:0] dv;
      int          eff;
      logic [9:0]  seq;
      logic        par;
   } vec_t;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic step();
      logic exp_tx, exp_pop, exp_busy;
      int   eff;
      @(negedge clk);
      reset      = rst_drv;
      div        = div_drv;
      fifo_empty = (fq.size() == 0);
      fifo_dout  = fifo_empty ? 8'($urandom) : fq[0];
      #1;
      exp_tx   = (exp_q.size() != 0) ? exp_q[0] : 1'b1;
      exp_pop  = (exp_q.size() == 0) && !fifo_empty && !rst_drv;
      exp_busy = (exp_q.size() != 0) || exp_pop;
      if (chk_en)
         check($sformatf("cycle%0d tx/pop/busy", cyc), {29'd0, tx, fifo_pop, busy},
               {29'd0, exp_tx, exp_pop, exp_busy});
      tx_s = tx; pop_s = fifo_pop; busy_s = busy;
      if (cyc < MAXC) begin
         tx_hist[cyc] = tx; pop_hist[cyc] = fifo_pop; busy_hist[cyc] = busy;
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      if (rst_drv) begin
         exp_q.delete();
      end else if (exp_pop) begin
         eff = (div_drv == 0) ? 1 : int'(div_drv);
         for (int k = 0; k < eff; k++) exp_q.push_back(1'b0);
         for (int b = 0; b < 8; b++)
            for (int k = 0; k < eff; k++) exp_q.push_back(fifo_dout[b]);
         for (int k = 0; k < eff * P; k++) exp_q.push_back(^fifo_dout);
         for (int k = 0; k < eff; k++) exp_q.push_back(1'b1);
      end
      if (fifo_pop && fq.size() != 0) void'(fq.pop_front());
      cyc++;
   endtask

   task automatic run_until_idle(input string name);
      int n = 0;
      do begin
         step();
         n++;
      end while ((fq.size() != 0 || busy_s) && n < 5000);
      if (n >= 5000) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s timeout: still busy after %0d cycles, required idle", name, n);
      end
   endtask

   function automatic int find_pop(input int from);
      for (int c = from; c < cyc && c < MAXC; c++)
         if (pop_hist[c]) return c;
      return -1;
   endfunction

   function automatic int find_fall(input int from);
      for (int c = from + 1; c < cyc && c < MAXC; c++)
         if (!busy_hist[c]) return c;
      return -1;
   endfunction

   task automatic check_frame(input string name, input int p, input int eff,
                              input logic [9:0] seq, input logic par);
      logic [9:0] got;
      for (int k = 0; k < 9; k++) got[k] = tx_hist[p + 1 + k * eff + eff / 2];
      got[9] = tx_hist[p + 1 + (9 + P) * eff + eff / 2];
      check({name, " bits"}, {22'd0, got}, {22'd0, seq});
`ifdef UART_TX_PARITY_EN
      check({name, " parity"}, {31'd0, tx_hist[p + 1 + 9 * eff + eff / 2]}, {31'd0, par});
`else
      if (par === 1'bx) $display("unused parity expectation in %s", name);
`endif
   endtask

   vec_t vecs[6];

   initial begin
      int c0, p, p2, fall, npop;
      vecs[0] = '{8'hA5, 16'd4, 4, 10'b1101001010, 1'b0};
      vecs[1] = '{8'h55, 16'd0, 1, 10'b1010101010, 1'b0};
      vecs[2] = '{8'h07, 16'd1, 1, 10'b1000001110, 1'b1};
      vecs[3] = '{8'h03, 16'd3, 3, 10'b1000000110, 1'b0};
      vecs[4] = '{8'hFF, 16'd2, 2, 10'b1111111110, 1'b0};
      vecs[5] = '{8'h96, 16'd5, 5, 10'b1100101100, 1'b0};

      // Reset state, with a byte waiting so a pop under reset would show.
      fq.push_back(8'h11);
      repeat (3) step();
      chk_en = 1'b1;
      step();
      check("reset tx", {31'd0, tx_s}, 32'd1);
      check("reset busy", {31'd0, busy_s}, 32'd0);
      check("reset pop", {31'd0, pop_s}, 32'd0);
      fq.delete();
      rst_drv = 1'b0;
      step();

      foreach (vecs[i]) begin
         c0 = cyc;
         div_drv = vecs[i].dv;
         fq.push_back(vecs[i].data);
         run_until_idle($sformatf("vec%0d", i));
         p = find_pop(c0);
         check($sformatf("vec%0d pop seen", i), {31'd0, p >= 0}, 32'd1);
         if (p >= 0) begin
            fall = find_fall(p);
            check($sformatf("vec%0d busy length", i), fall - p, FB * vecs[i].eff + 1);
            check_frame($sformatf("vec%0d", i), p, vecs[i].eff, vecs[i].seq, vecs[i].par);
         end
      end

      // Back-to-back 0x00, 0xFF at div=2.
      c0 = cyc;
      div_drv = 16'd2;
      fq.push_back(8'h00);
      fq.push_back(8'hFF);
      run_until_idle("b2b");
      npop = 0;
      for (int c = c0; c < cyc; c++) if (pop_hist[c]) npop++;
      check("b2b pop count", npop, 2);
      p = find_pop(c0);
      p2 = (p >= 0) ? find_pop(p + 1) : -1;
      check("b2b pops seen", {31'd0, p >= 0 && p2 >= 0}, 32'd1);
      if (p >= 0 && p2 >= 0) begin
         check("b2b pop spacing", p2 - p, FB * 2 + 1);
         check("b2b stop extension", {31'd0, tx_hist[p2]}, 32'd1);
         check("b2b second start", {31'd0, tx_hist[p2 + 1]}, 32'd0);
         check_frame("b2b first", p, 2, 10'b1000000000, 1'b0);
         check_frame("b2b second", p2, 2, 10'b1111111110, 1'b0);
      end

      // Divisor change mid-frame only affects the next frame.
      c0 = cyc;
      div_drv = 16'd4;
      fq.push_back(8'h5A);
      fq.push_back(8'hC3);
      repeat (12) step();
      div_drv = 16'd8;
      run_until_idle("divchg");
      p = find_pop(c0);
      p2 = (p >= 0) ? find_pop(p + 1) : -1;
      check("divchg pops seen", {31'd0, p >= 0 && p2 >= 0}, 32'd1);
      if (p >= 0 && p2 >= 0) begin
         check("divchg first frame", p2 - p, FB * 4 + 1);
         check("divchg second frame", find_fall(p2) - p2, FB * 8 + 1);
         check_frame("divchg second", p2, 8, 10'b1110000110, 1'b0);
      end

      // Reset during DATA bit 3, then a fresh frame for the next byte.
      c0 = cyc;
      div_drv = 16'd4;
      fq.push_back(8'h3C);
      fq.push_back(8'h96);
      step();
      p = find_pop(c0);
      check("rst pop seen", {31'd0, p >= 0}, 32'd1);
      if (p >= 0) begin
         while (cyc < p + 18) step();
         rst_drv = 1'b1;
         step();
         step();
         check("midrst tx", {31'd0, tx_s}, 32'd1);
         check("midrst busy", {31'd0, busy_s}, 32'd0);
         check("midrst pop", {31'd0, pop_s}, 32'd0);
         rst_drv = 1'b0;
         run_until_idle("midrst");
         p2 = find_pop(p + 1);
         check("midrst restart cycle", p2 - p, 20);
         if (p2 >= 0) check_frame("midrst fresh", p2, 4, 10'b1100101100, 1'b0);
      end

      // Random traffic, divisor churn and occasional resets.
      for (int i = 0; i < 4000; i++) begin
         div_drv = 16'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0 && fq.size() < 4) fq.push_back(8'($urandom));
         rst_drv = ($urandom_range(0, 299) == 0);
         step();
      end
      rst_drv = 1'b0;
      run_until_idle("random drain");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
